// File: rtl/present_pkg.sv
// Shared definitions for the PRESENT-128 round sequencer: controller states,
// round count and requester ids.
package present_pkg;

  localparam int NROUNDS = 31;
  localparam int RND_W   = 5;

  localparam logic REQ_HOST = 1'b0;
  localparam logic REQ_DM   = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_RUN,
    S_FINAL,
    S_DONE
  } state_t;

endpackage

// File: rtl/present_rr_arb.sv
// Two-way round-robin arbiter: a lone requester always wins, and a tie goes
// to the side named by ptr. ready is only raised when en is high.
module present_rr_arb (
  input  logic [1:0] valid,
  input  logic       en,
  input  logic       ptr,
  output logic       grant,
  output logic [1:0] ready
);

  // Pick the winner and qualify it with the enable.
  always_comb begin
    grant = ptr;
    unique case (valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      default: grant = ptr;
    endcase
    ready = {2{en}} & valid & (grant ? 2'b10 : 2'b01);
  end

endmodule

// File: rtl/present_round_ctrl.sv
// Round sequencer / arbiter for a shared iterative PRESENT-128 datapath.
// Grants one job at a time (host cipher vs. DM-PRESENT hash, round-robin),
// steps the datapath through 31 rounds plus final whitening and holds the
// result until the consumer takes it.
// Optional build macro PRESENT_ABORT_EN adds the abort port, which cancels
// an in-flight job and returns the controller to IDLE.
module present_round_ctrl
  import present_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req0_dec,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic             req1_dec,
  output logic             req1_ready,
  output logic             ks_load,
  output logic             ks_dec,
  input  logic             ks_rdy,
  output logic             dp_sel,
  output logic             dp_load,
  output logic             dp_round_en,
  output logic             dp_final,
  output logic [RND_W-1:0] round_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_id,
`ifdef PRESENT_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy
);

  state_t           state;
  state_t           state_nxt;
  logic             rr_ptr;
  logic             sel;
  logic             dec;
  logic [RND_W-1:0] idx;
  logic             grant;
  logic [1:0]       ready;
  logic             accept;
  logic             last_round;
  logic             abort_hit;

`ifdef PRESENT_ABORT_EN
  assign abort_hit = abort & (state != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // Requests are only considered in IDLE and never while reset is held,
  // so ready stays low during reset.
  present_rr_arb u_arb (
    .valid ({req1_valid, req0_valid}),
    .en    ((state == S_IDLE) & ~rst),
    .ptr   (rr_ptr),
    .grant (grant),
    .ready (ready)
  );

  assign accept     = |ready;
  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign last_round = dec ? (idx == RND_W'(1)) : (idx == RND_W'(NROUNDS));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; abort outranks every other exit condition.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = dec ? S_WAIT : S_RUN;
      S_WAIT:  if (ks_rdy) state_nxt = S_RUN;
      S_RUN:   if (last_round) state_nxt = S_FINAL;
      S_FINAL: state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort_hit) state_nxt = S_IDLE;
  end

  // Capture the granted job and advance the round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 1'b0;
      sel    <= 1'b0;
      dec    <= 1'b0;
    end else if (accept) begin
      sel    <= grant;
      dec    <= grant ? req1_dec : req0_dec;
      rr_ptr <= ~grant;
    end
  end

  // Round counter: 0 outside RUN, counts up for encrypt and down for decrypt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (abort_hit) begin
      idx <= '0;
    end else begin
      unique case (state)
        S_LOAD:  idx <= dec ? '0 : RND_W'(1);
        S_WAIT:  if (ks_rdy) idx <= RND_W'(NROUNDS);
        S_RUN:   if (last_round) idx <= '0;
                 else if (dec)   idx <= idx - RND_W'(1);
                 else            idx <= idx + RND_W'(1);
        default: idx <= '0;
      endcase
    end
  end

  assign ks_load     = (state == S_LOAD);
  assign dp_load     = (state == S_LOAD);
  assign dp_round_en = (state == S_RUN);
  assign dp_final    = (state == S_FINAL);
  assign out_valid   = (state == S_DONE);
  assign busy        = (state != S_IDLE);
  assign dp_sel      = sel;
  assign out_id      = sel;
  assign ks_dec      = dec;
  assign round_idx   = idx;

endmodule
